// File: rtl/video_pkg.sv
// Shared video definitions for the compositor slice: RGB565 field layout,
// field maxima, reference colours and the flash-level width.
package video_pkg;

  localparam int RGB_R_W   = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_W   = 5;
  localparam int RGB_R_OFS = 11;
  localparam int RGB_G_OFS = 5;
  localparam int RGB_B_OFS = 0;

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;

  localparam logic [RGB_R_W-1:0] RGB_R_MAX = 5'd31;
  localparam logic [RGB_G_W-1:0] RGB_G_MAX = 6'd63;
  localparam logic [RGB_B_W-1:0] RGB_B_MAX = 5'd31;

  localparam int FLASH_LEVEL_W = 4;

  typedef logic [FLASH_LEVEL_W-1:0] flash_level_t;

  // Field order matches the packed RGB565 word: r in [15:11], g in [10:5], b in [4:0].
  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel bus between the scanner/painter side and the compositor.
//   layer_pe / layer_color / bg_color : per-pixel layer candidates
//   in_hsync / in_vsync / in_de       : raw scanner timing
//   vga_hsync / vga_vsync / vga_de / vga_rgb : composited VGA output
// master = pixel source (drives candidates, observes VGA), slave = compositor.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 8
);
  logic [NUM_LAYERS-1:0]    layer_pe;
  logic [16*NUM_LAYERS-1:0] layer_color;
  logic [15:0]              bg_color;
  logic                     in_hsync;
  logic                     in_vsync;
  logic                     in_de;
  logic                     vga_hsync;
  logic                     vga_vsync;
  logic                     vga_de;
  logic [15:0]              vga_rgb;

  modport master (
    output layer_pe, layer_color, bg_color, in_hsync, in_vsync, in_de,
    input  vga_hsync, vga_vsync, vga_de, vga_rgb
  );

  modport slave (
    input  layer_pe, layer_color, bg_color, in_hsync, in_vsync, in_de,
    output vga_hsync, vga_vsync, vga_de, vga_rgb
  );
endinterface

// File: rtl/rgb565_brighten.sv
// Combinational white-flash brighten of one RGB565 pixel.
// Each field c with maximum M becomes c + (((M - c) * level) >> 4).
// Ports: i_color (RGB565 in), i_level (0..15), o_color (RGB565 out).
module rgb565_brighten
  import video_pkg::*;
(
  input  logic [15:0]  i_color,
  input  flash_level_t i_level,
  output logic [15:0]  o_color
);

  rgb565_t            w_in;
  rgb565_t            w_out;
  logic [RGB_R_W-1:0] w_r_room;
  logic [RGB_G_W-1:0] w_g_room;
  logic [RGB_B_W-1:0] w_b_room;

  assign w_in = rgb565_t'(i_color);

  // Headroom to full white; the scaled addition can never exceed it, so no saturation is needed.
  assign w_r_room = RGB_R_MAX - w_in.r;
  assign w_g_room = RGB_G_MAX - w_in.g;
  assign w_b_room = RGB_B_MAX - w_in.b;

  // 10-bit products: 63 * 15 = 945 is the largest case.
  assign w_out.r = w_in.r + 5'(({5'd0, w_r_room} * {6'd0, i_level}) >> 4);
  assign w_out.g = w_in.g + 6'(({4'd0, w_g_room} * {6'd0, i_level}) >> 4);
  assign w_out.b = w_in.b + 5'(({5'd0, w_b_room} * {6'd0, i_level}) >> 4);

  assign o_color = w_out;

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor feeding the VGA pins.
// Stage 1 resolves layer priority (index 0 highest) against the active layer
// mask with bg_color fallback; stage 2 applies the frame-synchronous white
// flash and blanks outside de. Syncs and de travel through both stages, so
// every output is exactly two clocks behind its input.
// Ports:
//   clk, rst              : pixel clock, synchronous active-high reset
//   pix (slave)           : layer candidates, raw timing in, VGA out
//   new_frame             : one-cycle frame boundary pulse
//   mask_wr, mask_data    : pending layer-mask write
//   flash_start           : flash trigger (takes effect at the next new_frame)
//   flash_busy            : high while the flash level is non-zero
//
// Flash control
//   state            | meaning
//   idle             | level == 0, nothing pending
//   armed            | flash_pending set, waiting for new_frame
//   running          | level != 0, stepping down every FLASH_STEP_FRAMES frames
//   running + armed  | re-trigger; restarts at the next new_frame
module layer_compositor
  import video_pkg::*;
#(
  parameter int NUM_LAYERS        = 8,
  parameter int FLASH_STEP_FRAMES = 2,
  parameter int FLASH_START_LEVEL = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_compositor_if.slave     pix,
  input  logic                  new_frame,
  input  logic                  mask_wr,
  input  logic [NUM_LAYERS-1:0] mask_data,
  input  logic                  flash_start,
  output logic                  flash_busy
);

  localparam logic [7:0]   DIV_RELOAD = 8'(FLASH_STEP_FRAMES - 1);
  localparam flash_level_t START_LVL  = flash_level_t'(FLASH_START_LEVEL);

  logic [NUM_LAYERS-1:0] r_pending_mask;
  logic [NUM_LAYERS-1:0] r_active_mask;
  logic [NUM_LAYERS-1:0] w_pending_nxt;
  logic [NUM_LAYERS-1:0] w_active_nxt;

  logic                  r_flash_pending;
  flash_level_t          r_level;
  logic [7:0]            r_div;
  logic                  r_flash_busy;
  logic                  w_pending_flag_nxt;
  flash_level_t          w_level_nxt;
  logic [7:0]            w_div_nxt;

  logic [15:0]           w_win_color;
  logic [15:0]           w_bright;

  logic [15:0]           r_s1_color;
  logic                  r_s1_hsync;
  logic                  r_s1_vsync;
  logic                  r_s1_de;

  logic [15:0]           r_s2_rgb;
  logic                  r_s2_hsync;
  logic                  r_s2_vsync;
  logic                  r_s2_de;

  // Double-buffered mask. A write coincident with new_frame goes straight to
  // the active mask. The pixel presented with new_frame is the first pixel of
  // the new frame, so stage 1 sees the post-boundary mask via w_active_nxt.
  always_comb begin
    w_pending_nxt = mask_wr   ? mask_data     : r_pending_mask;
    w_active_nxt  = new_frame ? w_pending_nxt : r_active_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending_mask <= '1;
      r_active_mask  <= '1;
    end else begin
      r_pending_mask <= w_pending_nxt;
      r_active_mask  <= w_active_nxt;
    end
  end

  // Flash level only moves on new_frame. The step divider counts down from
  // FLASH_STEP_FRAMES-1; at terminal count the level drops and it reloads.
  always_comb begin
    w_pending_flag_nxt = r_flash_pending | flash_start;
    w_level_nxt        = r_level;
    w_div_nxt          = r_div;
    if (new_frame) begin
      if (r_flash_pending || flash_start) begin
        w_pending_flag_nxt = 1'b0;
        w_level_nxt        = START_LVL;
        w_div_nxt          = DIV_RELOAD;
      end else if (r_level != '0) begin
        if (r_div == 8'd0) begin
          w_level_nxt = r_level - 1'b1;
          w_div_nxt   = DIV_RELOAD;
        end else begin
          w_div_nxt   = r_div - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flash_pending <= 1'b0;
      r_level         <= '0;
      r_div           <= 8'd0;
      r_flash_busy    <= 1'b0;
    end else begin
      r_flash_pending <= w_pending_flag_nxt;
      r_level         <= w_level_nxt;
      r_div           <= w_div_nxt;
      r_flash_busy    <= (w_level_nxt != '0);
    end
  end

  assign flash_busy = r_flash_busy;

  // Scanning from the lowest priority up lets the lowest visible index overwrite.
  always_comb begin
    w_win_color = pix.bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (pix.layer_pe[i] && w_active_nxt[i]) begin
        w_win_color = pix.layer_color[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_color <= RGB_BLACK;
      r_s1_hsync <= 1'b0;
      r_s1_vsync <= 1'b0;
      r_s1_de    <= 1'b0;
    end else begin
      r_s1_color <= w_win_color;
      r_s1_hsync <= pix.in_hsync;
      r_s1_vsync <= pix.in_vsync;
      r_s1_de    <= pix.in_de;
    end
  end

  rgb565_brighten u_brighten (
    .i_color (r_s1_color),
    .i_level (r_level),
    .o_color (w_bright)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_rgb   <= RGB_BLACK;
      r_s2_hsync <= 1'b0;
      r_s2_vsync <= 1'b0;
      r_s2_de    <= 1'b0;
    end else begin
      r_s2_rgb   <= r_s1_de ? w_bright : RGB_BLACK;
      r_s2_hsync <= r_s1_hsync;
      r_s2_vsync <= r_s1_vsync;
      r_s2_de    <= r_s1_de;
    end
  end

  assign pix.vga_rgb   = r_s2_rgb;
  assign pix.vga_hsync = r_s2_hsync;
  assign pix.vga_vsync = r_s2_vsync;
  assign pix.vga_de    = r_s2_de;

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer pixel compositor between the sprite/painter blocks and the VGA pins.
- Resolves per-pixel layer priority against a frame-synchronous layer mask, with a fixed-priority background fallback.
- Applies a frame-synchronous white-flash brighten effect for hit/game-over feedback.
- Delays hsync/vsync/de so they stay aligned with the 2-stage colour pipeline.

Parameters:
- NUM_LAYERS, 8, number of painter layer inputs; index 0 is highest priority; legal range 1..16.
- FLASH_STEP_FRAMES, 2, frames per flash-level decrement; legal range 1..255.
- FLASH_START_LEVEL, 15, flash level loaded on trigger; legal range 1..15.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- layer_pe  in  NUM_LAYERS  per-layer paint enable; bit i belongs to layer i.
- layer_color  in  16*NUM_LAYERS  per-layer RGB565 colour; layer i occupies bits [16i+15:16i].
- bg_color  in  16  background RGB565, used when no layer wins.
- in_hsync  in  1  raw horizontal sync from the scanner.
- in_vsync  in  1  raw vertical sync from the scanner.
- in_de  in  1  raw data enable from the scanner.
- new_frame  in  1  one-cycle pulse marking the frame boundary.
- mask_wr  in  1  write strobe for the pending layer mask.
- mask_data  in  NUM_LAYERS  pending layer-mask value; 1 = layer visible.
- flash_start  in  1  one-cycle flash trigger.
- vga_hsync  out  1  hsync delayed 2 cycles.
- vga_vsync  out  1  vsync delayed 2 cycles.
- vga_de  out  1  de delayed 2 cycles.
- vga_rgb  out  16  final RGB565 pixel.
- flash_busy  out  1  high while the active flash level is non-zero.

Behaviour:
- Reset, on any clk edge with rst=1:
  - vga_hsync, vga_vsync, vga_de, vga_rgb, flash_busy all 0.
  - Pending and active masks all-ones.
  - Flash pending flag, active level and divider all 0.
  - Both pipeline stages cleared.
  - rst mid-frame aborts any running flash.
- Mask double-buffer:
  - mask_wr loads pending_mask.
  - new_frame copies pending_mask into active_mask.
  - If mask_wr and new_frame are high in the same cycle, active_mask takes mask_data directly.
  - active_mask never changes mid-frame.
- Stage 1 (registered):
  - Winner is the lowest i with layer_pe[i] & active_mask[i]; s1_color = layer_color[i] of the winner.
  - If there is no winner, s1_color = bg_color.
  - Syncs and de are registered alongside.
- Stage 2 (registered):
  - With L = active flash level (0..15), each RGB565 field c with field maximum M (31/63/31) becomes c + (((M - c) * L) >> 4), truncated.
  - L = 0 passes the colour through unchanged.
  - vga_rgb = s1_de ? brightened : 16'h0000.
- Latency: exactly 2 clk cycles from every input to the matching output, in every mode; no bubbles or stalls.
- Flash control:
  - flash_start sets flash_pending.
  - At the next new_frame: level = FLASH_START_LEVEL, divider = 0, pending cleared.
  - Otherwise, at each new_frame with level != 0: divider increments; when it reaches FLASH_STEP_FRAMES - 1, level decrements and divider resets to 0.
  - flash_start while a flash is running re-arms the flash; it restarts at the next frame.
  - flash_start in the same cycle as new_frame loads the level at that new_frame (the start wins over the decrement).
  - The level changes only on new_frame, so there is no intra-frame tearing.
- flash_busy is registered and equals (level != 0).
- The layer colours and bg_color carry no timing requirement beyond the same-cycle alignment with layer_pe.

Decomposition:
- Shared package video_pkg:
  - RGB565 field widths and offsets.
  - RGB_WHITE = 16'hFFFF, RGB_BLACK = 16'h0000.
  - Field max constants 31/63/31.
  - FLASH_LEVEL_W = 4.
- One sub-module, rgb565_brighten: combinational; inputs colour[15:0] and level[3:0], output colour[15:0]. It is instantiated once in stage 2.
- The priority encoder and flash FSM stay inline.

Test Plan:
- Priority:
  - Stimulus: NUM_LAYERS=8, layer_pe=8'b0010_0100, layer2=16'hF800, layer5=16'h07E0, in_de=1, mask all-ones.
  - Required: vga_rgb=16'hF800 exactly 2 cycles later.
  - Stimulus: layer_pe=0, bg_color=16'h1234. Required: vga_rgb=16'h1234.
- Mask double-buffer:
  - Stimulus: mask_wr with 8'b1111_1011 mid-frame.
  - Required: layer2 still wins until new_frame; from the first pixel after new_frame, layer5 (16'h07E0) wins.
  - Stimulus: mask_wr and new_frame in the same cycle. Required: the new mask is active immediately.
- Blanking and sync alignment:
  - Stimulus: in_de=0 with a winning layer. Required: vga_rgb=0.
  - Stimulus: toggle in_hsync/in_vsync/in_de. Required: the outputs reproduce the same pattern with a 2-cycle delay.
- Flash arithmetic:
  - Setup: FLASH_START_LEVEL=15, colour 16'h0000.
  - Required: on the first frame after flash_start, vga_rgb = {5'd29, 6'd59, 5'd29} = 16'hEF7D, and flash_busy=1.
  - Required: level decrements every 2 frames; flash_busy falls after 30 frames; the pass-through colour is then 16'h0000.
- Flash boundary cases:
  - flash_start at level 3 → level 15 at the next new_frame.
  - flash_start coincident with new_frame → level 15 in that frame.
  - flash_start mid-frame → no colour change until new_frame.
- Reset mid-operation:
  - Stimulus: assert rst during an active flash with a custom mask.
  - Required: next cycle all outputs are 0, flash_busy=0, and the mask returns to all-ones; the first pixel after release is correct after 2 cycles.
